exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Parametrised execute stage for the next-generation Simple RISC core; replaces combinational ALU+shifter.
//  Operand B passes through the shift stage, then op is applied; flags N/V/Z are registered.
//  Adds multi-cycle MUL (shift-add) with start/busy/done handshake to the cpu controller.
// PARAMETERS
//  WIDTH   16  datapath width in bits (>=4); result, operands, shifter sized by it
//  MUL_EN  1   1: op 100 is sequential MUL; 0: op 100 treated as reserved
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; accepted only when busy=0
//  op         in   3      000 ADD, 001 SUB, 010 AND, 011 MVN, 100 MUL, 110 MOV, 101/111 reserved
//  shift_op   in   2      applied to val_B: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
//  en_status  in   1      flags update at completion when 1 (sampled with start)
//  val_A      in   WIDTH  operand A
//  val_B      in   WIDTH  operand B (pre-shift)
//  busy       out  1      MUL in progress; start ignored
//  done       out  1      one-cycle pulse: result valid
//  result     out  WIDTH  registered result, held until next completion
//  N, V, Z    out  1      registered status flags
// BEHAVIOUR
//  Reset (async, rst_n=0): busy=0, done=0, result=0, N=V=Z=0, FSM->IDLE, counter=0, latched operands=0.
//  Bs = shift(val_B, shift_op), computed at acceptance.
//  FSM states: IDLE, MUL. Completion = the edge that registers result and flags and sets done=1.
//  IDLE + start, single-cycle op (ADD/SUB/AND/MVN/MOV/reserved): complete at the same edge E; done=1 for cycle after E.
//  Results (mod 2^WIDTH): ADD A+Bs; SUB A-Bs; AND A&Bs; MVN ~Bs; MOV Bs; reserved: result unchanged, flags unchanged.
//  Flags (if en_status): Z=(result==0); N=result[WIDTH-1];
//   V: ADD/SUB signed overflow; AND/MVN/MOV 0; MUL 1 iff unsigned product >= 2^WIDTH.
//  en_status=0: N/V/Z hold; result still updated. Reserved op still pulses done.
//  IDLE + start, op=MUL (MUL_EN=1): at E latch A, Bs, en_status; clear acc and counter; busy=1; ->MUL.
//  MUL: one iteration per edge (LSB of multiplier: acc+=multiplicand; shift); WIDTH iterations.
//   Completion at E+WIDTH: result=low WIDTH bits, flags set, busy=0, done=1, ->IDLE.
//   Overflow tracked across iterations (any carry/bit beyond WIDTH).
//  start while busy=1: ignored, no queuing; inputs may change freely during MUL.
//  start in the done cycle: accepted (back-to-back); done drops unless new op is single-cycle,
//   in which case done stays 1 for the next cycle with the new result.
//  done without start in IDLE: low after one cycle.
//  rst_n low mid-MUL: immediate abort, all outputs to reset values, no done pulse.
//  No combinational path input->output; all outputs come straight from flops.
// TESTING (WIDTH=16)
//  ADD A=0x7FFF, Bs=0x0001, en_status=1 -> result 0x8000, N=1 V=1 Z=0, done 1 cycle after start edge.
//  SUB A=5,B=5 en_status=1 -> 0x0000 Z=1; then SUB 3-5 en_status=0 -> result 0xFFFE, flags still Z=1 N=0.
//  MVN B=0x8002 shift_op=11 -> Bs=0xC001, result 0x3FFE; LSR1 of 0x8002 -> MOV result 0x4001.
//  MUL 0x0123 x 0x0010 -> busy 16 cycles, done at edge E+16, result 0x1230, V=0;
//   0x0100 x 0x0100 -> 0x0000, Z=1 V=1.
//  start ADD pulsed at cycle 5 of a MUL -> ignored; MUL result unaffected; new ADD issued in done cycle completes next edge.
//  rst_n low at MUL cycle 7 -> busy/done/result/flags 0 immediately; after release, start ADD 2+2 -> 0x0004.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage: shift-then-ALU with registered result/flags, plus a sequential
// shift-add multiplier driven through a start/busy/done handshake.
module exec_unit #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       shift_op,
  input  logic             en_status,
  input  logic [WIDTH-1:0] val_A,
  input  logic [WIDTH-1:0] val_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             V,
  output logic             Z
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               n_q, n_d, v_q, v_d, z_q, z_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               en_q, en_d;

  logic [WIDTH-1:0]   bs;
  logic               is_mul;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_sum;
  logic signed [WIDTH:0] add_s, sub_s;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_v;
  logic               alu_upd;

  function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] b,
                                               input logic [1:0]       sh);
    case (sh)
      2'b01:   return {b[WIDTH-2:0], 1'b0};
      2'b10:   return {1'b0, b[WIDTH-1:1]};
      2'b11:   return {b[WIDTH-1], b[WIDTH-1:1]};
      default: return b;
    endcase
  endfunction

  assign bs        = shift_b(val_B, shift_op);
  assign is_mul    = MUL_EN && (op == 3'b100);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // One extra sign bit makes signed overflow visible as a disagreement of the top two bits.
  assign add_s     = $signed({val_A[WIDTH-1], val_A}) + $signed({bs[WIDTH-1], bs});
  assign sub_s     = $signed({val_A[WIDTH-1], val_A}) - $signed({bs[WIDTH-1], bs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      n_q      <= n_d;
      v_q      <= v_d;
      z_q      <= z_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && is_mul) state_d = S_MUL;
      S_MUL:   if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_r   = result_q;
    alu_v   = 1'b0;
    alu_upd = 1'b1;
    case (op)
      3'b000:  begin alu_r = add_s[WIDTH-1:0]; alu_v = add_s[WIDTH] ^ add_s[WIDTH-1]; end
      3'b001:  begin alu_r = sub_s[WIDTH-1:0]; alu_v = sub_s[WIDTH] ^ sub_s[WIDTH-1]; end
      3'b010:  alu_r = val_A & bs;
      3'b011:  alu_r = ~bs;
      3'b110:  alu_r = bs;
      default: alu_upd = 1'b0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    n_d      = n_q;
    v_d      = v_q;
    z_d      = z_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    en_d     = en_q;
    if (state_q == S_IDLE && start) begin
      if (is_mul) begin
        acc_d    = '0;
        cnt_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, val_A};
        mplier_d = bs;
        en_d     = en_status;
      end else begin
        // Reserved ops still complete, but leave result and flags alone.
        done_d = 1'b1;
        if (alu_upd) begin
          result_d = alu_r;
          if (en_status) begin
            n_d = alu_r[WIDTH-1];
            z_d = (alu_r == '0);
            v_d = alu_v;
          end
        end
      end
    end else if (state_q == S_MUL) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_iter) begin
        done_d   = 1'b1;
        result_d = acc_sum[WIDTH-1:0];
        if (en_q) begin
          n_d = acc_sum[WIDTH-1];
          z_d = (acc_sum[WIDTH-1:0] == '0);
          v_d = |acc_sum[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign busy   = (state_q == S_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign N      = n_q;
  assign V      = v_q;
  assign Z      = z_q;
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: the driver pushes predicted completions,
// an independent monitor pops and compares them whenever done is seen.
module tb_exec_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [1:0]   shift_op = 2'b00;
  logic         en_status = 1'b0;
  logic [W-1:0] val_A = '0;
  logic [W-1:0] val_B = '0;
  logic         busy, done, N, V, Z;
  logic [W-1:0] result;

  exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shift_op(shift_op),
    .en_status(en_status), .val_A(val_A), .val_B(val_B), .busy(busy),
    .done(done), .result(result), .N(N), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         n, v, z;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_n = 1'b0, m_v = 1'b0, m_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: written from the operation table, independent of the RTL structure.
  task automatic predict(input logic [2:0] o, input logic [1:0] sh, input logic en,
                         input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
    logic [W-1:0] bsv;
    logic [W-1:0] r;
    logic         v;
    logic         upd;
    int           sa, sb_i, s;
    int unsigned  p;
    case (sh)
      2'b00: bsv = b;
      2'b01: bsv = b << 1;
      2'b10: bsv = b >> 1;
      default: bsv = {b[W-1], b[W-1:1]};
    endcase
    sa = $signed(a);
    sb_i = $signed(bsv);
    upd = 1'b1;
    v = 1'b0;
    r = m_res;
    case (o)
      3'b000: begin r = a + bsv; s = sa + sb_i; v = (s > 32767) || (s < -32768); end
      3'b001: begin r = a - bsv; s = sa - sb_i; v = (s > 32767) || (s < -32768); end
      3'b010: r = a & bsv;
      3'b011: r = ~bsv;
      3'b110: r = bsv;
      3'b100: begin p = 32'(a) * 32'(bsv); r = p[W-1:0]; v = (p >= 32'h1_0000); end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      m_res = r;
      if (en) begin
        m_n = r[W-1];
        m_z = (r == '0);
        m_v = v;
      end
    end
    e.res = m_res;
    e.n = m_n;
    e.v = m_v;
    e.z = m_z;
    e.cyc = 0;
  endtask

  // Drives one request starting at the current time; caller aligns to a negedge.
  task automatic issue(input logic [2:0] o, input logic [1:0] sh, input logic en,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
    exp_t e;
    op = o; shift_op = sh; en_status = en; val_A = a; val_B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin
      predict(o, sh, en, a, b, e);
      e.cyc = (o == 3'b100) ? cyc + W : cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("flags_NVZ", {29'd0, N, V, Z}, {29'd0, e.n, e.v, e.z});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", {29'd0, N, V, Z}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    @(negedge clk); issue(3'b000, 2'b00, 1'b1, 16'h7FFF, 16'h0001, 1'b1); // 0x8000 N V
    @(negedge clk); issue(3'b001, 2'b00, 1'b1, 16'h0005, 16'h0005, 1'b1); // 0 Z
    @(negedge clk); issue(3'b001, 2'b00, 1'b0, 16'h0003, 16'h0005, 1'b1); // 0xFFFE, flags held
    @(negedge clk); issue(3'b011, 2'b11, 1'b1, 16'h0000, 16'h8002, 1'b1); // 0x3FFE
    @(negedge clk); issue(3'b110, 2'b10, 1'b1, 16'h0000, 16'h8002, 1'b1); // 0x4001
    @(negedge clk); issue(3'b000, 2'b01, 1'b1, 16'h0001, 16'h4000, 1'b1); // 0x8001 N
    @(negedge clk); issue(3'b010, 2'b00, 1'b1, 16'hF0F0, 16'h0FF0, 1'b1); // 0x00F0
    @(negedge clk); issue(3'b101, 2'b00, 1'b1, 16'h1111, 16'h2222, 1'b1); // reserved: hold
    @(negedge clk); issue(3'b001, 2'b00, 1'b1, 16'h8000, 16'h0001, 1'b1); // 0x7FFF V

    @(negedge clk); issue(3'b100, 2'b00, 1'b1, 16'h0123, 16'h0010, 1'b1); // 0x1230
    chk("mul_busy", 32'(busy), 32'd1);
    wait_done();
    @(negedge clk); issue(3'b100, 2'b00, 1'b1, 16'h0100, 16'h0100, 1'b1); // 0 Z V
    wait_done();

    // ADD during a MUL is dropped; another ADD issued in the done cycle runs back-to-back.
    @(negedge clk); issue(3'b100, 2'b00, 1'b1, 16'h0003, 16'h0007, 1'b1); // 0x0015
    repeat (3) @(negedge clk);
    issue(3'b000, 2'b00, 1'b1, 16'h1000, 16'h1000, 1'b0);
    chk("ignored_start_busy", 32'(busy), 32'd1);
    chk("ignored_start_done", 32'(done), 32'd0);
    wait_done();
    issue(3'b000, 2'b00, 1'b1, 16'h0010, 16'h0020, 1'b1); // 0x0030
    @(negedge clk);
    chk("b2b_done_held", 32'(done), 32'd1);

    // Abort a MUL partway through with reset.
    @(negedge clk); issue(3'b100, 2'b00, 1'b1, 16'h1234, 16'h0002, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", {29'd0, N, V, Z}, 32'd0);
    m_res = '0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); issue(3'b000, 2'b00, 1'b1, 16'h0002, 16'h0002, 1'b1); // 0x0004
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
